// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared pipeline constants and the hazard controller state encoding
package hazard_stall_controller_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID-stage hazard inputs, pipeline enables/flush/bubble, state and counters
interface hazard_stall_controller_if #(parameter int CNT_W = 32);
  import hazard_stall_controller_pkg::*;
  logic [REG_W-1:0] ID_RS1_i;
  logic [REG_W-1:0] ID_RS2_i;
  logic ID_UseRS2_i;
  logic ID_EX_MemRead_i;
  logic [REG_W-1:0] ID_EX_Rd_i;
  logic Branch_Taken_i;
  logic MemStall_i;
  logic PC_Write_o;
  logic IF_ID_Write_o;
  logic IF_ID_Flush_o;
  logic ID_EX_Bubble_o;
  logic Pipe_Enable_o;
  logic [1:0] State_o;
  logic [CNT_W-1:0] StallCycles_o;
  logic [CNT_W-1:0] Bubbles_o;
  logic [CNT_W-1:0] Flushes_o;
  modport master (
    output ID_RS1_i, ID_RS2_i, ID_UseRS2_i, ID_EX_MemRead_i, ID_EX_Rd_i, Branch_Taken_i, MemStall_i,
    input PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, Pipe_Enable_o, State_o,
    input StallCycles_o, Bubbles_o, Flushes_o
  );
  modport slave (
    input ID_RS1_i, ID_RS2_i, ID_UseRS2_i, ID_EX_MemRead_i, ID_EX_Rd_i, Branch_Taken_i, MemStall_i,
    output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, Pipe_Enable_o, State_o,
    output StallCycles_o, Bubbles_o, Flushes_o
  );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// sat_counter: CNT_W-bit up counter with synchronous active-low clear that sticks at all-ones
module sat_counter #(parameter int CNT_W = 32) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  always_ff @(posedge clk_i)
    cnt_o <= !rst_i ? '0 : (inc_i && !(&cnt_o)) ? cnt_o + 1'b1 : cnt_o;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use bubbles, ID branch flushes and cache-miss freeze with perf counters
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  hazard_stall_controller_if.slave bus
);
  state_t state, ret_state, mode;
  logic [1:0] lu_cnt;
  logic haz, frz, run, bub, flush;
  always_comb begin
    haz = bus.ID_EX_MemRead_i && bus.ID_EX_Rd_i != X0 &&
          (bus.ID_EX_Rd_i == bus.ID_RS1_i || (bus.ID_UseRS2_i && bus.ID_EX_Rd_i == bus.ID_RS2_i));
    frz = rst_i && bus.MemStall_i;
    mode = state == MEM_WAIT ? ret_state : state;
    run = mode != LU_STALL;
    bub = rst_i && !frz && (!run || haz);
    flush = rst_i && !frz && run && !haz && bus.Branch_Taken_i;
  end
  assign bus.PC_Write_o = !frz && !bub;
  assign bus.IF_ID_Write_o = !frz && !bub;
  assign bus.IF_ID_Flush_o = flush;
  assign bus.ID_EX_Bubble_o = bub;
  assign bus.Pipe_Enable_o = !frz;
  assign bus.State_o = state;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= RUN;
      ret_state <= RUN;
      lu_cnt <= '0;
    end else if (bus.MemStall_i) begin
      if (state != MEM_WAIT) begin
        ret_state <= run ? RUN : LU_STALL;
        state <= MEM_WAIT;
      end
    end else if (!run) begin
      lu_cnt <= lu_cnt - 2'd1;
      state <= lu_cnt == 2'd1 ? RUN : LU_STALL;
    end else if (haz && LOAD_BUBBLES > 1) begin
      state <= LU_STALL;
      lu_cnt <= 2'(LOAD_BUBBLES - 1);
    end else begin
      state <= RUN;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall (.clk_i(clk_i), .rst_i(rst_i), .inc_i(frz), .cnt_o(bus.StallCycles_o));
  sat_counter #(.CNT_W(CNT_W)) u_bub (.clk_i(clk_i), .rst_i(rst_i), .inc_i(bub), .cnt_o(bus.Bubbles_o));
  sat_counter #(.CNT_W(CNT_W)) u_flush (.clk_i(clk_i), .rst_i(rst_i), .inc_i(flush), .cnt_o(bus.Flushes_o));
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: four builds (1/2/3 bubbles, 3-bit counters) against a pending-bubble model
module tb_hazard_stall_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1, rs2, rd;
  logic use2, mr, br, ms;
  int checks = 0;
  int failures = 0;
  int lb[4] = '{1, 2, 3, 1};
  longint cmax[4] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd7};
  int pend[4];
  bit frz[4];
  longint sc_m[4], bc_m[4], fc_m[4];
  logic [102:0] obs[4];
  always #5 clk = ~clk;
  hazard_stall_controller_if #(.CNT_W(32)) b0 ();
  hazard_stall_controller_if #(.CNT_W(32)) b1 ();
  hazard_stall_controller_if #(.CNT_W(32)) b2 ();
  hazard_stall_controller_if #(.CNT_W(3)) b3 ();
  hazard_stall_controller #(.LOAD_BUBBLES(1), .CNT_W(32)) u0 (.clk_i(clk), .rst_i(rst_n), .bus(b0));
  hazard_stall_controller #(.LOAD_BUBBLES(2), .CNT_W(32)) u1 (.clk_i(clk), .rst_i(rst_n), .bus(b1));
  hazard_stall_controller #(.LOAD_BUBBLES(3), .CNT_W(32)) u2 (.clk_i(clk), .rst_i(rst_n), .bus(b2));
  hazard_stall_controller #(.LOAD_BUBBLES(1), .CNT_W(3)) u3 (.clk_i(clk), .rst_i(rst_n), .bus(b3));
  assign obs[0] = {b0.PC_Write_o, b0.IF_ID_Write_o, b0.IF_ID_Flush_o, b0.ID_EX_Bubble_o, b0.Pipe_Enable_o,
                   b0.State_o, b0.StallCycles_o, b0.Bubbles_o, b0.Flushes_o};
  assign obs[1] = {b1.PC_Write_o, b1.IF_ID_Write_o, b1.IF_ID_Flush_o, b1.ID_EX_Bubble_o, b1.Pipe_Enable_o,
                   b1.State_o, b1.StallCycles_o, b1.Bubbles_o, b1.Flushes_o};
  assign obs[2] = {b2.PC_Write_o, b2.IF_ID_Write_o, b2.IF_ID_Flush_o, b2.ID_EX_Bubble_o, b2.Pipe_Enable_o,
                   b2.State_o, b2.StallCycles_o, b2.Bubbles_o, b2.Flushes_o};
  assign obs[3] = {b3.PC_Write_o, b3.IF_ID_Write_o, b3.IF_ID_Flush_o, b3.ID_EX_Bubble_o, b3.Pipe_Enable_o,
                   b3.State_o, 32'(b3.StallCycles_o), 32'(b3.Bubbles_o), 32'(b3.Flushes_o)};
  always_comb begin
    b0.ID_RS1_i = rs1; b0.ID_RS2_i = rs2; b0.ID_UseRS2_i = use2; b0.ID_EX_MemRead_i = mr;
    b0.ID_EX_Rd_i = rd; b0.Branch_Taken_i = br; b0.MemStall_i = ms;
    b1.ID_RS1_i = rs1; b1.ID_RS2_i = rs2; b1.ID_UseRS2_i = use2; b1.ID_EX_MemRead_i = mr;
    b1.ID_EX_Rd_i = rd; b1.Branch_Taken_i = br; b1.MemStall_i = ms;
    b2.ID_RS1_i = rs1; b2.ID_RS2_i = rs2; b2.ID_UseRS2_i = use2; b2.ID_EX_MemRead_i = mr;
    b2.ID_EX_Rd_i = rd; b2.Branch_Taken_i = br; b2.MemStall_i = ms;
    b3.ID_RS1_i = rs1; b3.ID_RS2_i = rs2; b3.ID_UseRS2_i = use2; b3.ID_EX_MemRead_i = mr;
    b3.ID_EX_Rd_i = rd; b3.Branch_Taken_i = br; b3.MemStall_i = ms;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit hazard();
    return mr && rd != 0 && (rd == rs1 || (use2 && rd == rs2));
  endfunction
  task automatic compare();
    bit eb, ef;
    logic [4:0] ctl;
    logic [1:0] est;
    for (int k = 0; k < 4; k++) begin
      eb = (pend[k] > 0) || hazard();
      ef = !eb && br;
      ctl = !rst_n ? 5'b11001 : ms ? 5'b00000 : {!eb, !eb, ef, eb, 1'b1};
      est = frz[k] ? 2'd2 : pend[k] > 0 ? 2'd1 : 2'd0;
      check($sformatf("u%0d_ctl", k), 64'(obs[k][102:98]), 64'(ctl));
      check($sformatf("u%0d_state", k), 64'(obs[k][97:96]), 64'(est));
      check($sformatf("u%0d_stallcnt", k), 64'(obs[k][95:64]), sc_m[k]);
      check($sformatf("u%0d_bubcnt", k), 64'(obs[k][63:32]), bc_m[k]);
      check($sformatf("u%0d_flushcnt", k), 64'(obs[k][31:0]), fc_m[k]);
    end
  endtask
  task automatic advance();
    bit h;
    h = hazard();
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        pend[k] = 0; frz[k] = 0; sc_m[k] = 0; bc_m[k] = 0; fc_m[k] = 0;
      end else if (ms) begin
        frz[k] = 1;
        if (sc_m[k] < cmax[k]) sc_m[k]++;
      end else begin
        frz[k] = 0;
        if (pend[k] > 0 || h) begin
          pend[k] = pend[k] > 0 ? pend[k] - 1 : lb[k] - 1;
          if (bc_m[k] < cmax[k]) bc_m[k]++;
        end else if (br && fc_m[k] < cmax[k]) fc_m[k]++;
      end
    end
  endtask
  task automatic apply(input logic r, input logic s, input logic m, input logic b, input logic u,
                       input logic [4:0] d, input logic [4:0] a, input logic [4:0] c);
    @(negedge clk);
    rst_n = r; ms = s; mr = m; br = b; use2 = u; rd = d; rs1 = a; rs2 = c;
    #1 compare();
    @(posedge clk);
    #1 advance();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst_n = 0; ms = 0; mr = 0; br = 0; use2 = 0; rd = 0; rs1 = 0; rs2 = 0;
    for (int k = 0; k < 4; k++) begin
      pend[k] = 0; frz[k] = 0; sc_m[k] = 0; bc_m[k] = 0; fc_m[k] = 0;
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    apply(1, 0, 1, 0, 0, 5'd5, 5'd5, 5'd0);
    idle(3);
    apply(1, 0, 1, 0, 1, 5'd7, 5'd1, 5'd7);
    idle(3);
    apply(1, 0, 1, 0, 0, 5'd7, 5'd1, 5'd7);
    idle(1);
    apply(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    apply(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    apply(1, 0, 1, 1, 0, 5'd5, 5'd5, 5'd0);
    idle(3);
    apply(1, 0, 1, 0, 0, 5'd9, 5'd9, 5'd0);
    for (int i = 0; i < 4; i++) apply(1, 1, 0, 0, 0, 0, 0, 0);
    idle(4);
    apply(1, 0, 1, 0, 0, 5'd3, 5'd3, 5'd0);
    apply(1, 1, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 9; i++) apply(1, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    check("u3_flush_sat", 64'(obs[3][31:0]), 64'd7);
    for (int i = 0; i < 3000; i++)
      apply($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 2, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
